// File: rtl/load_use_scoreboard.sv
// Decode-stage hazard scoreboard: tracks in-flight writers, computes the bubble count and stalls decode.
// Optional operand forwarding is enabled by defining SCOREBOARD_FORWARD_EN.
module load_use_scoreboard #(
  parameter int DEPTH        = 3,
  parameter int LOAD_AVAIL   = 4,
  parameter int ALU_AVAIL    = 2,
  parameter int FLUSH_STAGES = 1,
  parameter int CNT_W        = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       dec_valid,
  input  logic [4:0]                 dec_rs1,
  input  logic [4:0]                 dec_rs2,
  input  logic                       dec_rs1_used,
  input  logic                       dec_rs2_used,
  input  logic [4:0]                 dec_rd,
  input  logic                       dec_reg_we,
  input  logic                       dec_mem_rr,
  input  logic                       hold,
  input  logic                       flush,
  output logic                       dec_ready,
  output logic [$clog2(DEPTH+2)-1:0] bubble,
  output logic [$clog2(DEPTH+2)-1:0] fwd_sel_rs1,
  output logic [$clog2(DEPTH+2)-1:0] fwd_sel_rs2,
  output logic [CNT_W-1:0]           stall_cnt
);
  localparam int BW = $clog2(DEPTH+2);
`ifdef SCOREBOARD_FORWARD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif
  // Without forwarding every result is only visible once it has left the last tracked stage.
  localparam int LD_AV = FWD_EN ? LOAD_AVAIL : DEPTH + 2;
  localparam int AL_AV = FWD_EN ? ALU_AVAIL  : DEPTH + 2;

  // Index j of each array holds pipeline stage j+2.
  logic [DEPTH-1:0] r_v;
  logic [DEPTH-1:0] r_we;
  logic [DEPTH-1:0] r_ld;
  logic [4:0]       r_rd [DEPTH];
  logic [CNT_W-1:0] r_cnt;

  logic             w_hit1, w_hit2, w_ld1, w_ld2;
  logic [BW-1:0]    w_k1, w_k2, w_need1, w_need2, w_need_max;
  logic [DEPTH-1:0] w_v_nxt;
  logic             w_stall;

  function automatic logic [BW-1:0] need_f(input logic hit, input logic ld,
                                           input logic [BW-1:0] k);
    int avail;
    avail = ld ? LD_AV : AL_AV;
    if (!hit || avail <= int'(k)) need_f = '0;
    else                          need_f = BW'(avail - int'(k));
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    sat_inc = (&c) ? c : c + CNT_W'(1);
  endfunction

  // Youngest producer search: scanning oldest to youngest lets the lowest stage overwrite.
  always_comb begin
    w_hit1 = 1'b0;
    w_ld1  = 1'b0;
    w_k1   = '0;
    w_hit2 = 1'b0;
    w_ld2  = 1'b0;
    w_k2   = '0;
    for (int j = DEPTH - 1; j >= 0; j--) begin
      if (r_v[j] && r_we[j] && (r_rd[j] != 5'd0)) begin
        if (dec_rs1_used && (r_rd[j] == dec_rs1)) begin
          w_hit1 = 1'b1;
          w_ld1  = r_ld[j];
          w_k1   = BW'(j + 2);
        end
        if (dec_rs2_used && (r_rd[j] == dec_rs2)) begin
          w_hit2 = 1'b1;
          w_ld2  = r_ld[j];
          w_k2   = BW'(j + 2);
        end
      end
    end
  end

  assign w_need1    = need_f(w_hit1, w_ld1, w_k1);
  assign w_need2    = need_f(w_hit2, w_ld2, w_k2);
  assign w_need_max = (w_need1 > w_need2) ? w_need1 : w_need2;
  assign bubble     = dec_valid ? w_need_max : '0;
  assign dec_ready  = dec_valid && (bubble == '0) && !hold && !flush;
  assign w_stall    = dec_valid && !dec_ready && !flush;
  assign stall_cnt  = r_cnt;

`ifdef SCOREBOARD_FORWARD_EN
  assign fwd_sel_rs1 = (dec_valid && (bubble == '0) && w_hit1) ? w_k1 : '0;
  assign fwd_sel_rs2 = (dec_valid && (bubble == '0) && w_hit2) ? w_k2 : '0;
`else
  assign fwd_sel_rs1 = '0;
  assign fwd_sel_rs2 = '0;
`endif

  // Valid bits: shift unless held, then a flush kills the youngest FLUSH_STAGES stages.
  always_comb begin
    w_v_nxt = r_v;
    if (!hold) begin
      w_v_nxt[0] = dec_ready;
      for (int j = 1; j < DEPTH; j++) w_v_nxt[j] = r_v[j-1];
    end
    if (flush) begin
      for (int j = 0; j < FLUSH_STAGES; j++) w_v_nxt[j] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v   <= '0;
      r_cnt <= '0;
    end else begin
      r_v <= w_v_nxt;
      if (w_stall) r_cnt <= sat_inc(r_cnt);
    end
  end

  // Entry payload only matters while its valid bit is set, so it carries no reset.
  always_ff @(posedge clk) begin
    if (!hold) begin
      r_we[0] <= dec_reg_we;
      r_ld[0] <= dec_mem_rr;
      r_rd[0] <= dec_rd;
      for (int j = 1; j < DEPTH; j++) begin
        r_we[j] <= r_we[j-1];
        r_ld[j] <= r_ld[j-1];
        r_rd[j] <= r_rd[j-1];
      end
    end
  end
endmodule

// File: tb/tb_load_use_scoreboard.sv
// Directed testbench for load_use_scoreboard (DEPTH=3, CNT_W=3 to reach counter saturation).
module tb_load_use_scoreboard;
  localparam int DEPTH = 3;
  localparam int CW    = 3;
  localparam int BW    = $clog2(DEPTH+2);
`ifdef SCOREBOARD_FORWARD_EN
  localparam bit FWD = 1'b1;
  localparam int LA  = 4;
  localparam int AA  = 2;
`else
  localparam bit FWD = 1'b0;
  localparam int LA  = DEPTH + 2;
  localparam int AA  = DEPTH + 2;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          dec_valid, dec_rs1_used, dec_rs2_used, dec_reg_we, dec_mem_rr, hold, flush;
  logic [4:0]    dec_rs1, dec_rs2, dec_rd;
  logic          dec_ready;
  logic [BW-1:0] bubble, fwd_sel_rs1, fwd_sel_rs2;
  logic [CW-1:0] stall_cnt;
  int            passed = 0;
  int            total  = 0;

  load_use_scoreboard #(.DEPTH(DEPTH), .LOAD_AVAIL(4), .ALU_AVAIL(2), .FLUSH_STAGES(1), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used), .dec_rd(dec_rd),
    .dec_reg_we(dec_reg_we), .dec_mem_rr(dec_mem_rr), .hold(hold), .flush(flush),
    .dec_ready(dec_ready), .bubble(bubble), .fwd_sel_rs1(fwd_sel_rs1),
    .fwd_sel_rs2(fwd_sel_rs2), .stall_cnt(stall_cnt));

  always #5 clk = ~clk;

  function automatic int exp_bub(input int avail, input int k);
    return (k <= DEPTH + 1 && avail > k) ? avail - k : 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(input logic v, input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                         input logic u2, input logic [4:0] rd, input logic we, input logic ld);
    dec_valid = v; dec_rs1 = rs1; dec_rs1_used = u1; dec_rs2 = rs2; dec_rs2_used = u2;
    dec_rd = rd; dec_reg_we = we; dec_mem_rr = ld;
  endtask

  task automatic clear();
    set_dec(0, 0, 0, 0, 0, 0, 0, 0);
    hold = 0; flush = 0;
    rst = 1; #1; rst = 0; #1;
  endtask

  task automatic test_reset();
    set_dec(0, 0, 0, 0, 0, 0, 0, 0);
    hold = 0; flush = 0; rst = 1;
    tick(); tick();
    total++; if (dec_ready !== 1'b0) $display("FAIL reset_ready got %0b want 0", dec_ready); else passed++;
    total++; if (bubble !== '0) $display("FAIL reset_bubble got %0d want 0", bubble); else passed++;
    total++; if (fwd_sel_rs1 !== '0 || fwd_sel_rs2 !== '0)
      $display("FAIL reset_fwd got %0d/%0d want 0/0", fwd_sel_rs1, fwd_sel_rs2); else passed++;
    total++; if (stall_cnt !== '0) $display("FAIL reset_cnt got %0d want 0", stall_cnt); else passed++;
    rst = 0; #1;
    set_dec(1, 5, 1, 6, 1, 0, 0, 0);
    #1;
    total++; if (dec_ready !== 1'b1 || bubble !== '0)
      $display("FAIL reset_empty got ready=%0b bubble=%0d want 1/0", dec_ready, bubble); else passed++;
    set_dec(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_load_use();
    int c, k, e, ef;
    clear();
    set_dec(1, 0, 0, 0, 0, 5, 1, 1);
    #1;
    total++; if (dec_ready !== 1'b1) $display("FAIL lu_issue got %0b want 1", dec_ready); else passed++;
    tick();
    set_dec(1, 5, 1, 0, 0, 6, 1, 0);
    c = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      k  = c + 2;
      e  = exp_bub(LA, k);
      ef = (FWD && e == 0 && k <= DEPTH + 1) ? k : 0;
      total++; if (bubble !== BW'(e)) $display("FAIL lu_bubble c=%0d got %0d want %0d", c, bubble, e); else passed++;
      total++; if (dec_ready !== (e == 0)) $display("FAIL lu_ready c=%0d got %0b want %0b", c, dec_ready, e == 0); else passed++;
      total++; if (fwd_sel_rs1 !== BW'(ef)) $display("FAIL lu_fwd c=%0d got %0d want %0d", c, fwd_sel_rs1, ef); else passed++;
      if (e == 0) break;
      tick();
      c++;
    end
    total++; if (stall_cnt !== CW'(LA - 2)) $display("FAIL lu_cnt got %0d want %0d", stall_cnt, LA - 2); else passed++;
    tick();
    set_dec(1, 0, 0, 6, 1, 0, 0, 0);
    #1;
    total++; if (bubble !== BW'(AA - 2)) $display("FAIL lu_reader_bubble got %0d want %0d", bubble, AA - 2); else passed++;
    total++; if (fwd_sel_rs2 !== BW'(FWD ? 2 : 0)) $display("FAIL lu_reader_fwd got %0d want %0d", fwd_sel_rs2, FWD ? 2 : 0); else passed++;
    total++; if (stall_cnt !== CW'(LA - 2)) $display("FAIL lu_cnt_after got %0d want %0d", stall_cnt, LA - 2); else passed++;
    set_dec(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_alu_fwd();
    clear();
    set_dec(1, 0, 0, 0, 0, 7, 1, 0);
    tick();
    set_dec(1, 1, 1, 7, 1, 8, 1, 0);
    #1;
    total++; if (bubble !== BW'(AA - 2)) $display("FAIL alu_bubble got %0d want %0d", bubble, AA - 2); else passed++;
    total++; if (dec_ready !== (AA == 2)) $display("FAIL alu_ready got %0b want %0b", dec_ready, AA == 2); else passed++;
    total++; if (fwd_sel_rs2 !== BW'(FWD ? 2 : 0) || fwd_sel_rs1 !== '0)
      $display("FAIL alu_fwd got %0d/%0d want 0/%0d", fwd_sel_rs1, fwd_sel_rs2, FWD ? 2 : 0); else passed++;
    set_dec(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_x0_unused();
    clear();
    set_dec(1, 0, 0, 0, 0, 0, 1, 1);
    tick();
    set_dec(1, 0, 1, 0, 1, 5, 1, 1);
    #1;
    total++; if (bubble !== '0 || dec_ready !== 1'b1)
      $display("FAIL x0_read got bubble=%0d ready=%0b want 0/1", bubble, dec_ready); else passed++;
    tick();
    set_dec(1, 5, 0, 5, 0, 9, 1, 0);
    #1;
    total++; if (bubble !== '0 || dec_ready !== 1'b1)
      $display("FAIL unused_src got bubble=%0d ready=%0b want 0/1", bubble, dec_ready); else passed++;
    total++; if (stall_cnt !== '0) $display("FAIL x0_cnt got %0d want 0", stall_cnt); else passed++;
    set_dec(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_youngest();
    clear();
    set_dec(1, 0, 0, 0, 0, 3, 1, 1);
    tick();
    set_dec(1, 0, 0, 0, 0, 3, 1, 0);
    tick();
    set_dec(1, 3, 1, 0, 0, 4, 1, 0);
    #1;
    total++; if (bubble !== BW'(exp_bub(AA, 2))) $display("FAIL young_bubble got %0d want %0d", bubble, exp_bub(AA, 2)); else passed++;
    total++; if (fwd_sel_rs1 !== BW'(FWD ? 2 : 0)) $display("FAIL young_fwd got %0d want %0d", fwd_sel_rs1, FWD ? 2 : 0); else passed++;
    set_dec(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_hold_flush();
    int e4;
    clear();
    set_dec(1, 0, 0, 0, 0, 5, 1, 1);
    tick();
    set_dec(1, 5, 1, 0, 0, 6, 1, 0);
    hold = 1;
    #1;
    total++; if (dec_ready !== 1'b0) $display("FAIL hold_ready got %0b want 0", dec_ready); else passed++;
    for (int i = 0; i < 4; i++) tick();
    total++; if (bubble !== BW'(LA - 2)) $display("FAIL hold_bubble got %0d want %0d", bubble, LA - 2); else passed++;
    total++; if (stall_cnt !== CW'(4)) $display("FAIL hold_cnt got %0d want 4", stall_cnt); else passed++;
    hold = 0;
    tick();
    total++; if (bubble !== BW'(LA - 3)) $display("FAIL unhold_bubble got %0d want %0d", bubble, LA - 3); else passed++;
    total++; if (stall_cnt !== CW'(5)) $display("FAIL unhold_cnt got %0d want 5", stall_cnt); else passed++;
    flush = 1;
    #1;
    total++; if (dec_ready !== 1'b0) $display("FAIL flush_ready got %0b want 0", dec_ready); else passed++;
    tick();
    flush = 0;
    total++; if (stall_cnt !== CW'(5)) $display("FAIL flush_cnt got %0d want 5", stall_cnt); else passed++;
    set_dec(1, 6, 1, 0, 0, 0, 0, 0);
    #1;
    total++; if (bubble !== '0 || fwd_sel_rs1 !== '0)
      $display("FAIL flush_dropped got bubble=%0d fwd=%0d want 0/0", bubble, fwd_sel_rs1); else passed++;
    set_dec(1, 5, 1, 0, 0, 0, 0, 0);
    #1;
    e4 = exp_bub(LA, 4);
    total++; if (bubble !== BW'(e4)) $display("FAIL flush_keep4 got %0d want %0d", bubble, e4); else passed++;
    total++; if (fwd_sel_rs1 !== BW'((FWD && e4 == 0) ? 4 : 0))
      $display("FAIL flush_keep4_fwd got %0d want %0d", fwd_sel_rs1, (FWD && e4 == 0) ? 4 : 0); else passed++;
    set_dec(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_flush_hold();
    clear();
    set_dec(1, 0, 0, 0, 0, 8, 1, 0);
    tick();
    set_dec(0, 0, 0, 0, 0, 0, 0, 0);
    hold = 1; flush = 1;
    tick();
    hold = 0; flush = 0;
    set_dec(1, 8, 1, 0, 0, 0, 0, 0);
    #1;
    total++; if (bubble !== '0 || fwd_sel_rs1 !== '0)
      $display("FAIL flush_hold got bubble=%0d fwd=%0d want 0/0", bubble, fwd_sel_rs1); else passed++;
    set_dec(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_rst_mid();
    clear();
    set_dec(1, 0, 0, 0, 0, 9, 1, 0);
    tick();
    set_dec(1, 9, 1, 0, 0, 0, 0, 0);
    #1;
    total++; if (bubble !== BW'(AA - 2)) $display("FAIL rst_pre_bubble got %0d want %0d", bubble, AA - 2); else passed++;
    tick();
    rst = 1;
    #1;
    total++; if (bubble !== '0 || dec_ready !== 1'b1)
      $display("FAIL rst_mid got bubble=%0d ready=%0b want 0/1", bubble, dec_ready); else passed++;
    total++; if (stall_cnt !== '0) $display("FAIL rst_mid_cnt got %0d want 0", stall_cnt); else passed++;
    rst = 0;
    set_dec(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
  endtask

  task automatic test_saturate();
    clear();
    set_dec(1, 0, 0, 0, 0, 5, 1, 1);
    tick();
    set_dec(1, 5, 1, 0, 0, 0, 0, 0);
    hold = 1;
    for (int i = 0; i < 10; i++) tick();
    total++; if (stall_cnt !== '1) $display("FAIL sat_cnt got %0d want %0d", stall_cnt, (1 << CW) - 1); else passed++;
    hold = 0;
    set_dec(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_alu_fwd();
    test_x0_unused();
    test_youngest();
    test_hold_flush();
    test_flush_hold();
    test_rst_mid();
    test_saturate();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
